// File: rtl/latency_tagged.sv
// Multi-tag transaction latency monitor: per-tag issue timestamps, exact
// retire latency, saturating issue/retire/sum counters, min/max, sticky errors.
// Ports: clk, rst_n; issue/issue_tag, retire/retire_tag, clear in;
// issue_cnt_r, retire_cnt_r, pending_cnt_r, aggregate_cnt_r,
// min_lat_r, max_lat_r, err_issue_busy_r, err_retire_idle_r out.
module latency_tagged #(
  parameter int W = 32,
  parameter int N = 8,
  localparam int TW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic [TW-1:0] issue_tag,
  input  logic          retire,
  input  logic [TW-1:0] retire_tag,
  input  logic          clear,
  output logic [W-1:0]  issue_cnt_r,
  output logic [W-1:0]  retire_cnt_r,
  output logic [TW:0]   pending_cnt_r,
  output logic [W-1:0]  aggregate_cnt_r,
  output logic [W-1:0]  min_lat_r,
  output logic [W-1:0]  max_lat_r,
  output logic          err_issue_busy_r,
  output logic          err_retire_idle_r
);

  logic [W-1:0]  now_q, now_d;
  logic [N-1:0]  valid_q, valid_d;
  logic [W-1:0]  ts_q [N];
  logic [W-1:0]  ts_d [N];
  logic [W-1:0]  icnt_q, icnt_d;
  logic [W-1:0]  rcnt_q, rcnt_d;
  logic [TW:0]   pend_q, pend_d;
  logic [W-1:0]  agg_q, agg_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  max_q, max_d;
  logic          eb_q, eb_d;
  logic          er_q, er_d;

  logic [W-1:0]  lat;
  logic [W:0]    agg_sum;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    now_d   = now_q + 1'b1;
    valid_d = valid_q;
    ts_d    = ts_q;
    icnt_d  = icnt_q;
    rcnt_d  = rcnt_q;
    agg_d   = agg_q;
    min_d   = min_q;
    max_d   = max_q;
    eb_d    = eb_q;
    er_d    = er_q;
    pend_d  = '0;
    // Modular subtraction gives the exact latency even across now_q wrap.
    lat     = now_q - ts_q[retire_tag];
    agg_sum = {1'b0, agg_q} + {1'b0, lat};

    if (clear) begin
      valid_d = '0;
      icnt_d  = '0;
      rcnt_d  = '0;
      agg_d   = '0;
      min_d   = '1;
      max_d   = '0;
      eb_d    = 1'b0;
      er_d    = 1'b0;
    end else begin
      // Retire first so a same-cycle issue can reuse the freed tag.
      if (retire) begin
        if (valid_q[retire_tag]) begin
          valid_d[retire_tag] = 1'b0;
          rcnt_d = sat_inc(rcnt_q);
          agg_d  = agg_sum[W] ? '1 : agg_sum[W-1:0];
          if (lat < min_q) min_d = lat;
          if (lat > max_q) max_d = lat;
        end else begin
          er_d = 1'b1;
        end
      end
      if (issue) begin
        if (!valid_d[issue_tag]) begin
          valid_d[issue_tag] = 1'b1;
          ts_d[issue_tag]    = now_q;
          icnt_d = sat_inc(icnt_q);
        end else begin
          eb_d = 1'b1;
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      pend_d = pend_d + {{TW{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < N; i++) ts_q[i] <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      pend_q  <= '0;
      agg_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      eb_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      now_q   <= now_d;
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) ts_q[i] <= ts_d[i];
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      agg_q   <= agg_d;
      min_q   <= min_d;
      max_q   <= max_d;
      eb_q    <= eb_d;
      er_q    <= er_d;
    end
  end

  assign issue_cnt_r       = icnt_q;
  assign retire_cnt_r      = rcnt_q;
  assign pending_cnt_r     = pend_q;
  assign aggregate_cnt_r   = agg_q;
  assign min_lat_r         = min_q;
  assign max_lat_r         = max_q;
  assign err_issue_busy_r  = eb_q;
  assign err_retire_idle_r = er_q;

endmodule

// File: tb/tb_latency_tagged.sv
// Bench for latency_tagged: a W=32 instance driven from a vector table
// through a scoreboard queue, plus a W=4 instance for saturation and wrap.
module tb_latency_tagged;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iss, ret, clr;
  logic [2:0]  it, rt;
  logic [31:0] ic, rc, agg, mn, mx;
  logic [3:0]  pend;
  logic        eb, er;

  logic        iss4, ret4, clr4;
  logic [2:0]  it4, rt4;
  logic [3:0]  ic4, rc4, agg4, mn4, mx4;
  logic [3:0]  pend4;
  logic        eb4, er4;

  latency_tagged #(.W(32), .N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue(iss), .issue_tag(it),
    .retire(ret), .retire_tag(rt),
    .clear(clr),
    .issue_cnt_r(ic), .retire_cnt_r(rc),
    .pending_cnt_r(pend), .aggregate_cnt_r(agg),
    .min_lat_r(mn), .max_lat_r(mx),
    .err_issue_busy_r(eb), .err_retire_idle_r(er)
  );

  latency_tagged #(.W(4), .N(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .issue(iss4), .issue_tag(it4),
    .retire(ret4), .retire_tag(rt4),
    .clear(clr4),
    .issue_cnt_r(ic4), .retire_cnt_r(rc4),
    .pending_cnt_r(pend4), .aggregate_cnt_r(agg4),
    .min_lat_r(mn4), .max_lat_r(mx4),
    .err_issue_busy_r(eb4), .err_retire_idle_r(er4)
  );

  typedef struct {
    int          pre;
    logic        iss;
    logic [2:0]  it;
    logic        ret;
    logic [2:0]  rt;
    logic        clr;
    logic [31:0] ic, rc, agg, mn, mx;
    logic [3:0]  pend;
    logic        eb, er;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_now;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  // Reference timestamp shared by both instances.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_now <= 0;
    else tb_now <= tb_now + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    int pre, logic i_, logic [2:0] it_, logic r_, logic [2:0] rt_,
    logic c_, logic [31:0] ic_, logic [31:0] rc_, logic [3:0] p_,
    logic [31:0] a_, logic [31:0] mn_, logic [31:0] mx_,
    logic eb_, logic er_);
    vec_t v;
    v.pre = pre; v.iss = i_; v.it = it_; v.ret = r_; v.rt = rt_;
    v.clr = c_; v.ic = ic_; v.rc = rc_; v.pend = p_; v.agg = a_;
    v.mn = mn_; v.mx = mx_; v.eb = eb_; v.er = er_;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    iss = 0; ret = 0; clr = 0;
    iss4 = 0; ret4 = 0; clr4 = 0;
  endtask

  task automatic step4(input logic i_, input logic [2:0] t_,
                       input logic r_, input logic [2:0] rt_);
    iss4 = i_; it4 = t_; ret4 = r_; rt4 = rt_;
    tick();
  endtask

  initial begin
    iss = 0; ret = 0; clr = 0; it = 0; rt = 0;
    iss4 = 0; ret4 = 0; clr4 = 0; it4 = 0; rt4 = 0;

    // pre, iss,it, ret,rt, clr | ic rc pend agg min max eb er
    // issue 3, retire 7 edges later
    vecs.push_back(mk(0,1,3,0,0,0, 1,0,1,0,ONES,0,0,0));
    vecs.push_back(mk(6,0,0,1,3,0, 1,1,0,7,7,7,0,0));
    // three tags, out-of-order retire: latencies 3,6,7
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0,1,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 2,0,2,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,2,0,0,0, 3,0,3,0,ONES,0,0,0));
    vecs.push_back(mk(2,0,0,1,2,0, 3,1,2,3,3,3,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 3,2,1,9,3,6,0,0));
    vecs.push_back(mk(1,0,0,1,1,0, 3,3,0,16,3,7,0,0));
    // idle retire, then double issue keeps first timestamp
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,ONES,0,0,0));
    vecs.push_back(mk(0,0,0,1,5,0, 0,0,0,0,ONES,0,0,1));
    vecs.push_back(mk(0,1,4,0,0,0, 1,0,1,0,ONES,0,0,1));
    vecs.push_back(mk(0,1,4,0,0,0, 1,0,1,0,ONES,0,1,1));
    vecs.push_back(mk(2,0,0,1,4,0, 1,1,0,4,4,4,1,1));
    // same-tag retire+issue while busy, then while idle
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,2,0,0,0, 1,0,1,0,ONES,0,0,0));
    vecs.push_back(mk(3,1,2,1,2,0, 2,1,1,4,4,4,0,0));
    vecs.push_back(mk(4,0,0,1,2,0, 2,2,0,9,4,5,0,0));
    vecs.push_back(mk(0,1,6,1,6,0, 3,2,1,9,4,5,0,1));
    // clear wins over a same-cycle issue
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0,1,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,5,0,0,0, 2,0,2,0,ONES,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 0,0,0,0,ONES,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0, 0,0,0,0,ONES,0,0,1));

    #12;
    chk("rst ic", ic, 0);
    chk("rst min", mn, ONES);
    chk("rst pend", {28'd0, pend}, 0);
    chk("rst flags", {30'd0, eb, er}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // W=4: two latency-9 retires saturate the sum at 15
    step4(1, 0, 0, 0);
    repeat (8) step4(0, 0, 0, 0);
    step4(0, 0, 1, 0);
    chk("w4 agg9", {28'd0, agg4}, 9);
    step4(1, 0, 0, 0);
    repeat (8) step4(0, 0, 0, 0);
    step4(0, 0, 1, 0);
    chk("w4 agg sat", {28'd0, agg4}, 15);
    chk("w4 rc", {28'd0, rc4}, 2);
    // issue at now=14, retire at now=3 after wrap
    for (int k = 0; k < 20 && (tb_now % 16) != 14; k++)
      step4(0, 0, 0, 0);
    chk("w4 sync14", tb_now % 16, 14);
    step4(1, 1, 0, 0);
    for (int k = 0; k < 20 && (tb_now % 16) != 3; k++)
      step4(0, 0, 0, 0);
    chk("w4 sync3", tb_now % 16, 3);
    step4(0, 0, 1, 1);
    chk("w4 wrap min", {28'd0, mn4}, 5);
    chk("w4 wrap max", {28'd0, mx4}, 9);
    chk("w4 wrap agg", {28'd0, agg4}, 15);
    chk("w4 wrap rc", {28'd0, rc4}, 3);
    chk("w4 err", {30'd0, eb4, er4}, 0);

    // table vectors via scoreboard
    foreach (vecs[i]) begin
      vec_t e;
      repeat (vecs[i].pre) tick();
      iss = vecs[i].iss; it = vecs[i].it;
      ret = vecs[i].ret; rt = vecs[i].rt;
      clr = vecs[i].clr;
      sb.push_back(vecs[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d ic", i), ic, e.ic);
      chk($sformatf("v%0d rc", i), rc, e.rc);
      chk($sformatf("v%0d pend", i), {28'd0, pend}, {28'd0, e.pend});
      chk($sformatf("v%0d agg", i), agg, e.agg);
      chk($sformatf("v%0d min", i), mn, e.mn);
      chk($sformatf("v%0d max", i), mx, e.mx);
      chk($sformatf("v%0d eb", i), {31'd0, eb}, {31'd0, e.eb});
      chk($sformatf("v%0d er", i), {31'd0, er}, {31'd0, e.er});
    end

    // async reset mid-traffic
    iss = 1; it = 2; tick();
    iss = 1; it = 3; tick();
    chk("pre-rst pend", {28'd0, pend}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst pend", {28'd0, pend}, 0);
    chk("arst ic", ic, 0);
    chk("arst min", mn, ONES);
    chk("arst w4 agg", {28'd0, agg4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ret = 1; rt = 2; tick();
    chk("post-rst er", {31'd0, er}, 1);
    chk("post-rst rc", rc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
